// File: rtl/pixel_stream_proc.sv
// Per-pixel point-operation stage between the UART rx FIFO and tx FIFO.
// Accepts one pixel, pops it, applies pass/offset/invert/threshold, pushes under tx backpressure.
module pixel_stream_proc #(
  parameter int unsigned OFFSET       = 50,
  parameter int unsigned THRESH       = 128,
  parameter int unsigned FRAME_PIXELS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic        rx_empty,
  input  logic [7:0]  r_data,
  output logic        rd_uart,
  input  logic        tx_full,
  output logic [7:0]  w_data,
  output logic        wr_uart,
  output logic [15:0] pixel_count,
  output logic        frame_done,
  output logic        busy
);

  localparam int unsigned PW = 8;
  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    PROC    = 2'd2,
    WRITE   = 2'd3
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_pix;
  logic [1:0]      r_mode;
  logic [PW:0]     w_sum;
  logic [PW-1:0]   w_result;
  logic            w_last;

  // Point operation on the captured pixel; the offset sum is one bit wider to detect saturation.
  always_comb begin
    w_sum    = {1'b0, r_pix} + (PW+1)'(OFFSET);
    w_result = r_pix;
    case (r_mode)
      2'b00: w_result = r_pix;
      2'b01: w_result = w_sum[PW] ? {PW{1'b1}} : w_sum[PW-1:0];
      2'b10: w_result = {PW{1'b1}} - r_pix;
      2'b11: w_result = (r_pix >= PW'(THRESH)) ? {PW{1'b1}} : {PW{1'b0}};
      default: w_result = r_pix;
    endcase
  end

  assign w_last = (pixel_count == CW'(FRAME_PIXELS - 1));

  // Control FSM; strobes are single-cycle and every output is a flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_pix       <= '0;
      r_mode      <= '0;
      rd_uart     <= 1'b0;
      wr_uart     <= 1'b0;
      w_data      <= '0;
      pixel_count <= '0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      rd_uart    <= 1'b0;
      wr_uart    <= 1'b0;
      frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (enable && !rx_empty) begin
            r_pix   <= r_data;
            r_mode  <= mode;
            rd_uart <= 1'b1;
            busy    <= 1'b1;
            r_state <= CAPTURE;
          end
        end
        CAPTURE: r_state <= PROC;
        PROC: begin
          w_data  <= w_result;
          r_state <= WRITE;
        end
        WRITE: begin
          if (!tx_full) begin
            wr_uart <= 1'b1;
            busy    <= 1'b0;
            r_state <= IDLE;
            // Frame wrap and the done pulse land on the same push.
            if (w_last) begin
              pixel_count <= '0;
              frame_done  <= 1'b1;
            end else begin
              pixel_count <= pixel_count + CW'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
